// File: rtl/seq_cmp_pkg.sv
// Shared types for the sequential magnitude comparator.
// Signed compare support is enabled with SEQ_CMP_SIGNED_EN.
package seq_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } cmp_state_e;

    typedef enum logic [1:0] {
        EQ = 2'd0,
        GT = 2'd1,
        LT = 2'd2
    } cmp_res_e;

    function automatic cmp_res_e to_res(input logic gt, input logic lt);
        cmp_res_e r;
        r = EQ;
        unique case (1'b1)
            gt:      r = GT;
            lt:      r = LT;
            default: r = EQ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seq_magnitude_comparator_cmp_chunk.sv
// Combinational unsigned comparator for one operand chunk.
// Exactly one of gt/eq/lt is high for any input pair.
module cmp_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    assign gt = (a > b);
    assign eq = (a == b);
    assign lt = (a < b);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle WIDTH-bit comparator, CHUNK bits per cycle, MSB chunk first.
// Define SEQ_CMP_SIGNED_EN to add the signed_mode port (two's-complement).
module seq_magnitude_comparator
    import seq_cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SEQ_CMP_SIGNED_EN
    input  logic             signed_mode,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0]  IDX_TOP  = IDXW'(NCHUNK - 1);
    localparam logic [CHUNK-1:0] MSB_MASK = CHUNK'(1) << (CHUNK - 1);

    if ((CHUNK < 1) || (CHUNK > WIDTH) || (WIDTH % CHUNK != 0)) begin : g_bad_cfg
        $error("seq_magnitude_comparator: WIDTH must be a multiple of CHUNK");
    end

    cmp_state_e       state;
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             flip;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic             c_gt;
    logic             c_eq;
    logic             c_lt;
    cmp_res_e         chunk_res;

`ifdef SEQ_CMP_SIGNED_EN
    logic sm_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sm_q <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            sm_q <= signed_mode;
        end
    end

    // Biasing the sign bit turns the top chunk into an unsigned compare.
    assign flip = sm_q && (idx == IDX_TOP);
`else
    assign flip = 1'b0;
`endif

    assign a_chunk = a_q[32'(idx) * CHUNK +: CHUNK] ^ (flip ? MSB_MASK : '0);
    assign b_chunk = b_q[32'(idx) * CHUNK +: CHUNK] ^ (flip ? MSB_MASK : '0);

    cmp_chunk #(
        .CHUNK (CHUNK)
    ) u_cmp_chunk (
        .a  (a_chunk),
        .b  (b_chunk),
        .gt (c_gt),
        .eq (c_eq),
        .lt (c_lt)
    );

    assign chunk_res = to_res(c_gt, c_lt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            gt        <= 1'b0;
            eq        <= 1'b0;
            lt        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        idx      <= IDX_TOP;
                        in_ready <= 1'b0;
                        state    <= CMP;
                    end
                end
                CMP: begin
                    if (!c_eq || idx == '0) begin
                        gt        <= (chunk_res == GT);
                        eq        <= (chunk_res == EQ);
                        lt        <= (chunk_res == LT);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        gt        <= 1'b0;
                        eq        <= 1'b0;
                        lt        <= 1'b0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
